// File: rtl/pfd_ctrl_pkg.sv
// rtl/pfd_ctrl_pkg.sv - shared state encodings and default parameters for pfd_lock_ctrl
package pfd_ctrl_pkg;

    typedef enum logic [1:0] {
        M_DISABLED = 2'd0,
        M_ACQUIRE  = 2'd1,
        M_LOCKED   = 2'd2
    } main_state_t;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_MEAS = 2'd1,
        E_CLR  = 2'd2,
        E_DONE = 2'd3
    } ev_state_t;

    localparam int DEF_W          = 8;
    localparam int DEF_RST_CYCLES = 3;
    localparam int DEF_LOCK_CNT   = 16;
    localparam int DEF_UNLOCK_CNT = 4;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for detector outputs
module sync2 (
    input  logic clk1,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pfd_lock_ctrl.sv
// rtl/pfd_lock_ctrl.sv - PFD event sequencer, error-width measurement and lock hysteresis
module pfd_lock_ctrl
    import pfd_ctrl_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         dn,
    input  logic [W-1:0] win,
    output logic         pfd_rst,
    output logic         locked,
    output logic         lock_lost,
    output logic         err_valid,
    output logic [W-1:0] err_width,
    output logic         err_sign
);

    localparam logic [W-1:0] WMAX = '1;

    logic up_s, dn_s;

    sync2 u_sync_up (.clk1(clk1), .rst(rst), .d(up), .q(up_s));
    sync2 u_sync_dn (.clk1(clk1), .rst(rst), .d(dn), .q(dn_s));

    main_state_t  main_q, main_d;
    ev_state_t    ev_q, ev_d;
    logic [W-1:0] width_q, width_d;
    logic         sign_q, sign_d, tmo_q, tmo_d;
    logic [3:0]   clr_q, clr_d;
    logic [7:0]   good_q, good_d, bad_q, bad_d;
    logic         ev_good_q, done_entry, lost_d, abort;

    // Event engine; any disable aborts the event silently.
    always_comb begin
        ev_d       = ev_q;
        width_d    = width_q;
        sign_d     = sign_q;
        tmo_d      = tmo_q;
        clr_d      = clr_q;
        done_entry = 1'b0;
        abort      = (main_q == M_DISABLED) || !en;
        case (ev_q)
            E_IDLE: begin
                if (up_s && dn_s) begin
                    ev_d = E_CLR; width_d = '0; sign_d = 1'b0; tmo_d = 1'b0; clr_d = '0;
                end else if (up_s ^ dn_s) begin
                    ev_d = E_MEAS; width_d = {{(W-1){1'b0}}, 1'b1}; sign_d = up_s; tmo_d = 1'b0;
                end
            end
            E_MEAS: begin
                if (up_s ^ dn_s) begin
                    width_d = width_q + 1'b1;
                    if (width_q == WMAX - 1'b1) begin
                        tmo_d = 1'b1; ev_d = E_CLR; clr_d = '0;
                    end
                end else begin
                    ev_d = E_CLR; clr_d = '0;
                end
            end
            E_CLR: begin
                if (clr_q == 4'(RST_CYCLES - 1)) begin
                    ev_d = E_DONE; done_entry = 1'b1;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: begin
                if (!up_s && !dn_s) ev_d = E_IDLE;
            end
        endcase
        if (abort) begin
            ev_d       = E_IDLE;
            done_entry = 1'b0;
        end
    end

    // Lock hysteresis, advanced once per reported event.
    always_comb begin
        main_d = main_q;
        good_d = good_q;
        bad_d  = bad_q;
        lost_d = 1'b0;
        case (main_q)
            M_DISABLED: begin
                good_d = '0;
                bad_d  = '0;
                if (en) main_d = M_ACQUIRE;
            end
            default: begin
                if (err_valid) begin
                    if (ev_good_q) begin
                        good_d = (good_q == 8'hFF) ? good_q : good_q + 1'b1;
                        bad_d  = '0;
                    end else begin
                        bad_d  = (bad_q == 8'hFF) ? bad_q : bad_q + 1'b1;
                        good_d = '0;
                    end
                end
                if (main_q == M_ACQUIRE && good_d == 8'(LOCK_CNT)) begin
                    main_d = M_LOCKED; good_d = '0; bad_d = '0;
                end else if (main_q == M_LOCKED && bad_d == 8'(UNLOCK_CNT)) begin
                    main_d = M_ACQUIRE; good_d = '0; bad_d = '0; lost_d = 1'b1;
                end
            end
        endcase
        if (!en) begin
            main_d = M_DISABLED;
            good_d = '0;
            bad_d  = '0;
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            main_q    <= M_DISABLED;
            ev_q      <= E_IDLE;
            width_q   <= '0;
            sign_q    <= 1'b0;
            tmo_q     <= 1'b0;
            clr_q     <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            ev_good_q <= 1'b0;
            pfd_rst   <= 1'b1;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            err_valid <= 1'b0;
            err_width <= '0;
            err_sign  <= 1'b0;
        end else begin
            main_q    <= main_d;
            ev_q      <= ev_d;
            width_q   <= width_d;
            sign_q    <= sign_d;
            tmo_q     <= tmo_d;
            clr_q     <= clr_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            pfd_rst   <= (main_d == M_DISABLED) || (ev_d == E_CLR);
            locked    <= (main_d == M_LOCKED);
            lock_lost <= lost_d;
            err_valid <= done_entry;
            if (done_entry) begin
                err_width <= width_q;
                err_sign  <= sign_q;
                ev_good_q <= (width_q <= win) && !tmo_q;
            end
        end
    end

endmodule

// File: tb/tb_pfd_lock_ctrl.sv
// tb/tb_pfd_lock_ctrl.sv - scoreboard bench for pfd_lock_ctrl
module tb_pfd_lock_ctrl;

    logic       clk1 = 1'b0;
    logic       rst, en, up, dn;
    logic [7:0] win;
    logic       pfd_rst, locked, lock_lost, err_valid, err_sign;
    logic [7:0] err_width;

    typedef struct {
        logic [7:0] w;
        logic       s;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ev_cnt = 0;
    int   lost_cnt = 0;
    int   ev0, lost0, n;

    pfd_lock_ctrl dut (
        .clk1(clk1), .rst(rst), .en(en), .up(up), .dn(dn), .win(win),
        .pfd_rst(pfd_rst), .locked(locked), .lock_lost(lock_lost),
        .err_valid(err_valid), .err_width(err_width), .err_sign(err_sign)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk1) begin
        if (!rst) begin
            if (lock_lost) lost_cnt++;
            if (err_valid) begin
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    check("err_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("err_width", 32'(err_width), 32'(e.w));
                    check("err_sign", 32'(err_sign), 32'(e.s));
                end
            end
        end
    end

    task automatic wait_pfd_rst(input int limit);
        int k = 0;
        while (pfd_rst !== 1'b1 && k < limit) begin
            @(negedge clk1);
            k++;
        end
        check("pfd_rst_rise", 32'(pfd_rst), 32'd1);
    endtask

    task automatic count_rst_run();
        int k = 0;
        while (pfd_rst === 1'b1 && k < 20) begin
            k++;
            @(negedge clk1);
        end
        check("pfd_rst_cycles", k, 3);
    endtask

    task automatic run_event(input bit up_lead, input int lead, input int ew, input bit es);
        exp_q.push_back('{w: 8'(ew), s: es});
        @(negedge clk1);
        if (lead == 0) begin
            up = 1'b1; dn = 1'b1;
        end else begin
            if (up_lead) up = 1'b1; else dn = 1'b1;
            repeat (lead) @(negedge clk1);
            up = 1'b1; dn = 1'b1;
        end
        wait_pfd_rst(600);
        count_rst_run();
        up = 1'b0; dn = 1'b0;
        repeat (10) @(negedge clk1);
    endtask

    task automatic restart();
        @(negedge clk1); en = 1'b0;
        repeat (2) @(negedge clk1); en = 1'b1;
        repeat (3) @(negedge clk1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0; win = 8'd4;
        // 1: reset values, and unchanged after release with en low
        repeat (3) @(negedge clk1);
        check("rst_pfd_rst", 32'(pfd_rst), 1);
        check("rst_locked", 32'(locked), 0);
        check("rst_lock_lost", 32'(lock_lost), 0);
        check("rst_err_valid", 32'(err_valid), 0);
        check("rst_err_width", 32'(err_width), 0);
        check("rst_err_sign", 32'(err_sign), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk1);
        check("dis_pfd_rst", 32'(pfd_rst), 1);
        check("dis_locked", 32'(locked), 0);
        check("dis_err_valid", 32'(err_valid), 0);

        // 2: up leads by 3
        en = 1'b1;
        repeat (3) @(negedge clk1);
        check("acq_pfd_rst", 32'(pfd_rst), 0);
        run_event(1'b1, 3, 3, 1'b1);
        check("t2_locked", 32'(locked), 0);

        // 3: lock after 16 good, lose after 4 bad
        restart();
        for (int i = 0; i < 16; i++) begin
            run_event(1'b0, 2, 2, 1'b0);
            if (i == 14) check("t3_locked_15", 32'(locked), 0);
        end
        check("t3_locked_16", 32'(locked), 1);
        lost0 = lost_cnt;
        for (int i = 0; i < 4; i++) begin
            run_event(1'b0, 10, 10, 1'b0);
            if (i == 2) check("t3_locked_3bad", 32'(locked), 1);
        end
        check("t3_unlocked", 32'(locked), 0);
        check("t3_lock_lost_cycles", lost_cnt - lost0, 1);

        // 4: simultaneous rise counts as a good zero-width event
        restart();
        for (int i = 0; i < 15; i++) run_event(1'b0, 1, 1, 1'b0);
        check("t4_locked_15", 32'(locked), 0);
        run_event(1'b0, 0, 0, 1'b0);
        check("t4_locked_16", 32'(locked), 1);

        // 5: stuck up -> timeout at 255, DONE holds while up stays high
        ev0 = ev_cnt;
        exp_q.push_back('{w: 8'd255, s: 1'b1});
        @(negedge clk1); up = 1'b1;
        wait_pfd_rst(400);
        count_rst_run();
        repeat (10) @(negedge clk1);
        check("t5_done_pfd_rst", 32'(pfd_rst), 0);
        check("t5_one_event", ev_cnt - ev0, 1);
        up = 1'b0;
        repeat (6) @(negedge clk1);
        check("t5_locked", 32'(locked), 1);

        // 6a: en dropped mid-MEAS
        ev0 = ev_cnt; lost0 = lost_cnt;
        up = 1'b1;
        repeat (6) @(negedge clk1);
        en = 1'b0;
        @(negedge clk1);
        check("t6a_pfd_rst", 32'(pfd_rst), 1);
        check("t6a_locked", 32'(locked), 0);
        up = 1'b0;
        repeat (5) @(negedge clk1);
        check("t6a_no_event", ev_cnt - ev0, 0);
        check("t6a_no_lost", lost_cnt - lost0, 0);

        // 6b: en dropped during CLR, then counters shown to restart at zero
        en = 1'b1;
        repeat (3) @(negedge clk1);
        up = 1'b1; dn = 1'b1;
        wait_pfd_rst(50);
        en = 1'b0;
        @(negedge clk1);
        check("t6b_pfd_rst", 32'(pfd_rst), 1);
        up = 1'b0; dn = 1'b0;
        repeat (8) @(negedge clk1);
        check("t6b_no_event", ev_cnt - ev0, 0);
        en = 1'b1;
        repeat (3) @(negedge clk1);
        for (int i = 0; i < 16; i++) begin
            run_event(1'b1, 2, 2, 1'b1);
            if (i == 14) check("t6b_locked_15", 32'(locked), 0);
        end
        check("t6b_locked_16", 32'(locked), 1);

        // 6c: async reset in LOCKED
        #2 rst = 1'b1;
        #1;
        check("t6c_locked_async", 32'(locked), 0);
        check("t6c_pfd_rst_async", 32'(pfd_rst), 1);
        @(negedge clk1); rst = 1'b0;
        repeat (4) @(negedge clk1);
        check("t6c_restart_pfd_rst", 32'(pfd_rst), 0);
        check("t6c_restart_locked", 32'(locked), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
